// File: rtl/dsp_seq_divider.sv
// Iterative restoring divider, N = Q*D + Rm, with per-operand signedness select.
// Build with DIV_TWO_BIT_EN defined to retire two quotient bits per cycle.
`timescale 1ns/1ps
module dsp_seq_divider #(
   parameter int unsigned NW = 32,
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [NW-1:0] N,
   input  logic [DW-1:0] D,
   input  logic          TCN,
   input  logic          TCD,
   output logic          busy,
   output logic          done,
   output logic [NW-1:0] Q,
   output logic [DW-1:0] Rm,
   output logic          DZ,
   output logic          OVF
);

`ifdef DIV_TWO_BIT_EN
   localparam int unsigned ITERS = NW / 2;
`else
   localparam int unsigned ITERS = NW;
`endif
   localparam int unsigned CW       = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);
   localparam logic [NW-1:0] N_MIN    = {1'b1, {(NW-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

   state_t          r_state, w_state_nxt;
   logic [NW-1:0]   r_n;
   logic [DW-1:0]   r_d;
   logic            r_tcn, r_tcd;
   logic [NW-1:0]   r_quo;
   logic [DW-1:0]   r_rem;
   logic [DW-1:0]   r_dabs;
   logic            r_qneg, r_rneg, r_dz, r_ovf;
   logic [CW-1:0]   r_cnt;
   logic            w_n_neg, w_d_neg;
   logic [DW+NW-1:0] w_rq1, w_rq_nxt;

   // One restoring step on the {rem,quo} pair; the compare is the DW+1-bit trial subtract.
   function automatic logic [DW+NW-1:0] div_step(input logic [DW+NW-1:0] rq,
                                                 input logic [DW-1:0]    dv);
      logic [DW:0]   sh;
      logic [NW-1:0] q;
      sh = rq[DW+NW-1:NW-1];
      q  = {rq[NW-2:0], 1'b0};
      if (sh >= {1'b0, dv}) begin
         q[0] = 1'b1;
         return {sh[DW-1:0] - dv, q};
      end
      return {sh[DW-1:0], q};
   endfunction

   assign w_n_neg = r_tcn & r_n[NW-1];
   assign w_d_neg = r_tcd & r_d[DW-1];
   assign w_rq1   = div_step({r_rem, r_quo}, r_dabs);
`ifdef DIV_TWO_BIT_EN
   assign w_rq_nxt = div_step(w_rq1, r_dabs);
`else
   assign w_rq_nxt = w_rq1;
`endif

   assign busy = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_PREP;
         S_PREP:  w_state_nxt = S_ITER;
         S_ITER:  if (r_cnt == '0) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_n    <= '0;
         r_d    <= '0;
         r_tcn  <= 1'b0;
         r_tcd  <= 1'b0;
         r_quo  <= '0;
         r_rem  <= '0;
         r_dabs <= '0;
         r_qneg <= 1'b0;
         r_rneg <= 1'b0;
         r_dz   <= 1'b0;
         r_ovf  <= 1'b0;
         r_cnt  <= '0;
         done   <= 1'b0;
         Q      <= '0;
         Rm     <= '0;
         DZ     <= 1'b0;
         OVF    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_n   <= N;
                  r_d   <= D;
                  r_tcn <= TCN;
                  r_tcd <= TCD;
               end
            end
            S_PREP: begin
               r_quo  <= w_n_neg ? -r_n : r_n;
               r_dabs <= w_d_neg ? -r_d : r_d;
               r_rem  <= '0;
               r_qneg <= w_n_neg ^ w_d_neg;
               r_rneg <= w_n_neg;
               r_dz   <= (r_d == '0);
               r_ovf  <= r_tcn & r_tcd & (r_n == N_MIN) & (r_d == '1);
               r_cnt  <= CNT_LAST;
            end
            S_ITER: begin
               {r_rem, r_quo} <= w_rq_nxt;
               r_cnt          <= r_cnt - CW'(1);
            end
            S_FIX: begin
               done <= 1'b1;
               DZ   <= r_dz;
               OVF  <= r_ovf;
               // Divide-by-zero overrides whatever the iteration produced.
               if (r_dz) begin
                  Q  <= '1;
                  Rm <= r_n[DW-1:0];
               end else begin
                  Q  <= r_qneg ? -r_quo : r_quo;
                  Rm <= r_rneg ? -r_rem : r_rem;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dsp_seq_divider.sv
// Self-checking bench for dsp_seq_divider: directed vector table, handshake
// corner cases and randomized operations against an arithmetic reference model.
`timescale 1ns/1ps
module tb_dsp_seq_divider;

`ifdef DIV_TWO_BIT_EN
   localparam int LAT = 18;
`else
   localparam int LAT = 34;
`endif

   typedef struct packed {
      logic [31:0] q;
      logic [15:0] rm;
      logic        dz;
      logic        ovf;
   } res_t;

   typedef struct {
      logic [31:0] n;
      logic [15:0] d;
      logic        tcn;
      logic        tcd;
      res_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] N;
   logic [15:0] D;
   logic        TCN, TCD;
   logic        busy, done;
   logic [31:0] Q;
   logic [15:0] Rm;
   logic        DZ, OVF;

   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   dsp_seq_divider #(.NW(32), .DW(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .N(N), .D(D),
      .TCN(TCN), .TCD(TCD), .busy(busy), .done(done), .Q(Q), .Rm(Rm),
      .DZ(DZ), .OVF(OVF)
   );

   // Truncating division on the operands' numeric values, plus the two special cases.
   function automatic res_t model(input logic [31:0] n, input logic [15:0] d,
                                  input logic tcn, input logic tcd);
      longint nv, dv, qv, rv;
      res_t   r;
      nv = tcn ? longint'($signed(n)) : longint'({32'b0, n});
      dv = tcd ? longint'($signed(d)) : longint'({48'b0, d});
      r  = '0;
      if (dv == 0) begin
         r.q  = '1;
         r.rm = n[15:0];
         r.dz = 1'b1;
      end else if (tcn && tcd && n == 32'h8000_0000 && d == 16'hFFFF) begin
         r.q   = n;
         r.ovf = 1'b1;
      end else begin
         qv   = nv / dv;
         rv   = nv % dv;
         r.q  = qv[31:0];
         r.rm = rv[15:0];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic addv(input logic [31:0] n, input logic [15:0] d, input logic tcn,
                       input logic tcd, input logic [31:0] q, input logic [15:0] rm,
                       input logic dz, input logic ovf);
      vec_t v;
      v.n = n; v.d = d; v.tcn = tcn; v.tcd = tcd;
      v.e.q = q; v.e.rm = rm; v.e.dz = dz; v.e.ovf = ovf;
      vecs.push_back(v);
   endtask

   // Drives a request for one edge, then scrambles the operand inputs.
   task automatic launch(input logic [31:0] n, input logic [15:0] d,
                         input logic tcn, input logic tcd);
      start = 1'b1; N = n; D = d; TCN = tcn; TCD = tcd;
      @(posedge clk); #1;
      start = 1'b0;
      N   = $urandom;
      D   = 16'($urandom);
      TCN = 1'($urandom);
      TCD = 1'($urandom);
      check("busy_on_accept", busy, 1'b1);
      check("done_low_after_accept", done, 1'b0);
   endtask

   task automatic wait_done(input int first, output int lat);
      logic busy_ok;
      busy_ok = 1'b1;
      lat = first;
      while (!done && lat < 200) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      check("done_seen", done, 1'b1);
      check("busy_while_running", busy_ok, 1'b1);
      check("busy_low_at_done", busy, 1'b0);
   endtask

   task automatic check_res(input string tag, input res_t e, input int lat);
      check({tag, ".Q"}, Q, e.q);
      check({tag, ".Rm"}, Rm, e.rm);
      check({tag, ".DZ"}, DZ, e.dz);
      check({tag, ".OVF"}, OVF, e.ovf);
      check({tag, ".latency"}, lat, LAT);
   endtask

   task automatic do_op(input string tag, input logic [31:0] n, input logic [15:0] d,
                        input logic tcn, input logic tcd, input res_t e);
      int lat;
      launch(n, d, tcn, tcd);
      wait_done(0, lat);
      check_res(tag, e, lat);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, ".busy"}, busy, 1'b0);
      check({tag, ".done"}, done, 1'b0);
      check({tag, ".Q"}, Q, 32'h0);
      check({tag, ".Rm"}, Rm, 16'h0);
      check({tag, ".DZ"}, DZ, 1'b0);
      check({tag, ".OVF"}, OVF, 1'b0);
   endtask

   initial begin
      int   lat;
      logic quiet;
      res_t e;
      logic [31:0] rn;
      logic [15:0] rd;
      logic        rtn, rtd;

      addv(32'd1000,      16'd7,      0, 0, 32'd142,      16'd6,      0, 0);
      addv(32'hFFFFFC18,  16'd7,      1, 1, 32'hFFFFFF72, 16'hFFFA,   0, 0);
      addv(32'd1000,      16'hFFF9,   1, 1, 32'hFFFFFF72, 16'd6,      0, 0);
      addv(32'h12345678,  16'h0000,   0, 0, 32'hFFFFFFFF, 16'h5678,   1, 0);
      addv(32'd10,        16'd3,      0, 0, 32'd3,        16'd1,      0, 0);
      addv(32'h80000000,  16'hFFFF,   1, 1, 32'h80000000, 16'h0000,   0, 1);
      addv(32'h80000000,  16'hFFFF,   0, 0, 32'h00008000, 16'h8000,   0, 0);
      addv(32'd1000,      16'hFFF9,   0, 1, 32'hFFFFFF72, 16'd6,      0, 0);
      addv(32'hFFFFFC18,  16'hFFF9,   1, 0, 32'h00000000, 16'hFC18,   0, 0);
      addv(32'hFFFFFFEB,  16'd7,      1, 1, 32'hFFFFFFFD, 16'h0000,   0, 0);
      addv(32'hFFFFFFFF,  16'hFFFF,   0, 0, 32'h00010001, 16'h0000,   0, 0);
      addv(32'd5,         16'h0000,   1, 1, 32'hFFFFFFFF, 16'h0005,   1, 0);
      addv(32'hFFFFFFFF,  16'd1,      0, 0, 32'hFFFFFFFF, 16'h0000,   0, 0);
      addv(32'h7FFFFFFF,  16'h8000,   1, 1, 32'hFFFF0001, 16'h7FFF,   0, 0);

      reset_n = 1'b0; start = 1'b0; N = '0; D = '0; TCN = 1'b0; TCD = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // A second request arriving mid-operation must not disturb the result.
      launch(32'd1000, 16'd7, 1'b0, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      start = 1'b1; N = 32'd9; D = 16'd2; TCN = 1'b0; TCD = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(5, lat);
      check_res("ignored_start", '{q: 32'd142, rm: 16'd6, dz: 1'b0, ovf: 1'b0}, lat);
      quiet = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) quiet = 1'b0;
      end
      check("no_queued_op", quiet, 1'b1);

      // Table entries run back-to-back: each start coincides with the previous done.
      foreach (vecs[i])
         do_op($sformatf("vec%0d", i), vecs[i].n, vecs[i].d, vecs[i].tcn, vecs[i].tcd, vecs[i].e);

      for (int i = 0; i < 150; i++) begin
         rn  = $urandom;
         rd  = 16'($urandom);
         rtn = 1'($urandom);
         rtd = 1'($urandom);
         case ($urandom_range(0, 7))
            0: rd = 16'h0000;
            1: rd = 16'hFFFF;
            2: rn = 32'h80000000;
            3: rd = 16'($urandom_range(1, 15));
            default: ;
         endcase
         e = model(rn, rd, rtn, rtd);
         do_op($sformatf("rand%0d", i), rn, rd, rtn, rtd, e);
      end

      // Reset during iteration aborts with no done and leaves the block idle.
      launch(32'h12345678, 16'h0123, 1'b0, 1'b0);
      repeat (9) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      #1;
      check_zero_outputs("mid_reset");
      @(posedge clk); #1;
      reset_n = 1'b1;
      quiet = 1'b1;
      repeat (50) begin
         @(posedge clk); #1;
         if (done || busy) quiet = 1'b0;
      end
      check("quiet_after_reset", quiet, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
